// File: rtl/pc_fetch_if.sv
// Fetch-unit bus bundle: branch/advance controls, instruction-memory handshake, fetched-instruction outputs.
interface pc_fetch_if;
  logic [31:0] i_branch;
  logic        i_take;
  logic        i_adv;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic        o_valid;
  logic        o_misalign;

  modport master (
    input  i_branch, i_take, i_adv, imem_ack, imem_data,
    output imem_req, imem_addr, o_instr, o_pc, o_valid, o_misalign
  );

  modport slave (
    output i_branch, i_take, i_adv, imem_ack, imem_data,
    input  imem_req, imem_addr, o_instr, o_pc, o_valid, o_misalign
  );
endinterface

// File: rtl/pc_fetch.sv
// PC fetch unit: one outstanding imem read, holds the instruction until consumed, then steps PC by 4 or a branch offset.
// Stalls indefinitely awaiting ack; a misaligned next-PC parks in ERR until reset.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  pc_fetch_if.master    bus
);

  typedef enum logic [1:0] {BOOT, REQ, HOLD, ERR} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_nxt;

  // Carry out is dropped, so the PC wraps modulo 2^32.
  assign pc_nxt = pc + (bus.i_take ? bus.i_branch : 32'd4);

  always_ff @(posedge clk) begin
    if (rst) state <= BOOT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BOOT: state_nxt = REQ;
      REQ:  if (bus.imem_ack) state_nxt = HOLD;
      HOLD: if (bus.i_adv) state_nxt = (pc_nxt[1:0] == 2'b00) ? REQ : ERR;
      ERR:  state_nxt = ERR;
      default: state_nxt = BOOT;
    endcase
  end

  always_comb begin
    bus.imem_req   = 1'b0;
    bus.o_valid    = 1'b0;
    bus.o_misalign = 1'b0;
    case (state)
      REQ:  bus.imem_req   = 1'b1;
      HOLD: bus.o_valid    = 1'b1;
      ERR:  bus.o_misalign = 1'b1;
      default: ;
    endcase
  end

  // The faulting PC stays in pc; instr_pc keeps the last good address.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      instr    <= 32'd0;
      instr_pc <= 32'd0;
    end else begin
      if (state == REQ && bus.imem_ack) begin
        instr    <= bus.imem_data;
        instr_pc <= pc;
      end
      if (state == HOLD && bus.i_adv) pc <= pc_nxt;
    end
  end

  assign bus.imem_addr = pc;
  assign bus.o_instr   = instr;
  assign bus.o_pc      = instr_pc;

endmodule
